// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch tracker: widths, tag/pointer types,
// the per-entry record and the age-from-head helper.
package branch_pkg;

  localparam int ADDR_WIDTH = 17;
  localparam int TAG_WIDTH  = 3;
  localparam int DEPTH      = 1 << TAG_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [TAG_WIDTH-1:0]  tag_t;
  typedef logic [TAG_WIDTH:0]    ptr_t;

  typedef struct packed {
    logic  valid;
    logic  resolved;
    addr_t pc;
    logic  pred;
    addr_t alt_pc;
    logic  actual;
  } entry_t;

  // Distance of a tag from the head slot, i.e. how many older entries precede it.
  function automatic tag_t age_of(tag_t tag, tag_t head_idx);
    return tag - head_idx;
  endfunction

endpackage

// File: rtl/branch_tracker_if.sv
// Bundle of fetch-side allocation, execute-side resolve and predictor-update signals.
// Optional stat counters appear when BRANCH_TRACKER_STATS_EN is defined.
interface branch_tracker_if;
  import branch_pkg::*;

  logic  alloc_en;
  addr_t alloc_pc;
  logic  alloc_pred_take;
  addr_t alloc_alt_pc;
  tag_t  alloc_tag;
  logic  full;
  logic  res_en;
  tag_t  res_tag;
  logic  res_take;
  logic  mispredict;
  addr_t redirect_pc;
  logic  branch_record_en;
  addr_t branch_address;
  logic  branch_take;
`ifdef BRANCH_TRACKER_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  modport master (
    output alloc_en, alloc_pc, alloc_pred_take, alloc_alt_pc,
    output res_en, res_tag, res_take,
    input  alloc_tag, full, mispredict, redirect_pc,
    input  branch_record_en, branch_address, branch_take
`ifdef BRANCH_TRACKER_STATS_EN
    , input stat_branches, stat_mispredicts
`endif
  );

  modport slave (
    input  alloc_en, alloc_pc, alloc_pred_take, alloc_alt_pc,
    input  res_en, res_tag, res_take,
    output alloc_tag, full, mispredict, redirect_pc,
    output branch_record_en, branch_address, branch_take
`ifdef BRANCH_TRACKER_STATS_EN
    , output stat_branches, stat_mispredicts
`endif
  );

endinterface

// File: rtl/branch_tracker.sv
// In-order tracker of predicted branches: allocate at tail, resolve by tag, retire at head
// into the predictor update port. Define BRANCH_TRACKER_STATS_EN to add branch/mispredict counters.
module branch_tracker
  import branch_pkg::*;
(
  input logic              clk,
  input logic              rst,
  branch_tracker_if.slave  bus
);

  entry_t entries [DEPTH];
  ptr_t   head;
  ptr_t   tail;
  ptr_t   count;
  tag_t   head_idx;
  tag_t   tail_idx;
  tag_t   res_age;
  entry_t res_entry;
  entry_t head_entry;
  logic   res_hit;
  logic   res_miss;
  logic   drain;
  logic   do_alloc;

  assign head_idx      = head[TAG_WIDTH-1:0];
  assign tail_idx      = tail[TAG_WIDTH-1:0];
  assign count         = tail - head;
  assign bus.full      = (count == ptr_t'(DEPTH));
  assign bus.alloc_tag = tail_idx;

  always_comb begin
    res_entry  = entries[bus.res_tag];
    head_entry = entries[head_idx];
    res_age    = age_of(bus.res_tag, head_idx);
    res_hit    = bus.res_en && res_entry.valid && !res_entry.resolved;
    res_miss   = res_hit && (bus.res_take != res_entry.pred);
    drain      = head_entry.valid && head_entry.resolved;
    // A mispredict makes anything fetched this cycle wrong-path, so it is not allocated.
    do_alloc   = bus.alloc_en && !bus.full && !res_miss;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      head                 <= '0;
      tail                 <= '0;
      bus.mispredict       <= 1'b0;
      bus.redirect_pc      <= '0;
      bus.branch_record_en <= 1'b0;
      bus.branch_address   <= '0;
      bus.branch_take      <= 1'b0;
    end else begin
      bus.mispredict       <= res_miss;
      bus.branch_record_en <= drain;
      if (res_miss) begin
        bus.redirect_pc <= res_entry.alt_pc;
      end
      if (drain) begin
        bus.branch_address      <= head_entry.pc;
        bus.branch_take         <= head_entry.actual;
        entries[head_idx].valid <= 1'b0;
        head                    <= head + ptr_t'(1);
      end
      if (res_hit) begin
        entries[bus.res_tag].resolved <= 1'b1;
        entries[bus.res_tag].actual   <= bus.res_take;
      end
      // Keep the mispredicted entry; everything younger is squashed and tail rewinds past it.
      if (res_miss) begin
        tail <= head + ptr_t'(res_age) + ptr_t'(1);
        for (int i = 0; i < DEPTH; i++) begin
          if (age_of(tag_t'(i), head_idx) > res_age) begin
            entries[i].valid <= 1'b0;
          end
        end
      end else if (do_alloc) begin
        entries[tail_idx] <= '{valid:    1'b1,
                               resolved: 1'b0,
                               pc:       bus.alloc_pc,
                               pred:     bus.alloc_pred_take,
                               alt_pc:   bus.alloc_alt_pc,
                               actual:   1'b0};
        tail <= tail + ptr_t'(1);
      end
    end
  end

`ifdef BRANCH_TRACKER_STATS_EN
  // Counters saturate rather than wrap so long runs never report a misleadingly small value.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.stat_branches    <= '0;
      bus.stat_mispredicts <= '0;
    end else begin
      if (drain && (bus.stat_branches != '1)) begin
        bus.stat_branches <= bus.stat_branches + 32'd1;
      end
      if (res_miss && (bus.stat_mispredicts != '1)) begin
        bus.stat_mispredicts <= bus.stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule
